usb_upload_arbiter: RTL and testbench



---
 rtl/usb_upload_pkg.sv | 10 +
 rtl/usb_upload_rr_pick.sv | 23 ++
 rtl/usb_upload_arbiter.sv | 89 ++++++++
 tb/tb_usb_upload_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_upload_pkg.sv
// usb_upload_pkg: shared encodings and defaults for the USB CDC upload arbiter.
package usb_upload_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
  localparam int SRC_CMD = 0;
  localparam int SRC_UART = 1;
  localparam int SRC_BUS = 2;
  localparam int SRC_DSM = 3;
  localparam int DEF_MAX_PKT_LEN = 256;
  localparam int DEF_IDLE_TIMEOUT = 1024;
endpackage

// File: rtl/usb_upload_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  always_comb begin
    int j;
    j = 0;
    any = |req;
    idx = '0;
    // walk backwards so the candidate closest to ptr is written last
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = (j >= N) ? j - N : j;
      if (req[j]) idx = W'(j);
    end
  end
endmodule

// File: rtl/usb_upload_arbiter.sv
// usb_upload_arbiter: packet-level round-robin share of the USB CDC upload byte path.
module usb_upload_arbiter
  import usb_upload_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*8-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [7:0]                 up_data,
  output logic                       up_valid,
  input  logic                       up_afull,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       err_overlen
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int LW = $clog2(MAX_PKT_LEN + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  state_t state;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic pick_any, g_valid, g_last, hs;
  logic [7:0] g_data;
  logic [LW-1:0] len_cnt;
  logic [TW-1:0] idle_cnt;
  rr_pick #(.N(NUM_SRC)) u_pick (
    .req(src_valid),
    .ptr(rr_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );
  assign g_valid = src_valid[grant_idx];
  assign g_last = src_last[grant_idx];
  assign g_data = src_data[{grant_idx, 3'b000} +: 8];
  assign busy = state == XFER;
  assign hs = busy && g_valid && !up_afull;
  always_comb begin
    src_ready = '0;
    src_ready[grant_idx] = busy && !up_afull;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      len_cnt <= '0;
      idle_cnt <= '0;
      up_data <= '0;
      up_valid <= 1'b0;
      err_timeout <= 1'b0;
      err_overlen <= 1'b0;
    end else begin
      up_valid <= hs;
      err_timeout <= 1'b0;
      err_overlen <= 1'b0;
      if (hs) up_data <= g_data;
      if (state == IDLE) begin
        if (pick_any) begin
          state <= XFER;
          grant_idx <= pick_idx;
          rr_ptr <= (pick_idx == IW'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;
          len_cnt <= '0;
          idle_cnt <= '0;
        end
      end else if (hs) begin
        len_cnt <= len_cnt + 1'b1;
        idle_cnt <= '0;
        // an explicit last wins over the length guard on the same byte
        if (g_last) state <= IDLE;
        else if (len_cnt == LW'(MAX_PKT_LEN - 1)) begin
          state <= IDLE;
          err_overlen <= 1'b1;
        end
      end else if (!g_valid && !up_afull) begin
        idle_cnt <= idle_cnt + 1'b1;
        if (idle_cnt == TW'(IDLE_TIMEOUT - 1)) begin
          state <= IDLE;
          err_timeout <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_upload_arbiter.sv
// tb_usb_upload_arbiter: directed checks of grant order, framing, backpressure and release guards.
module tb_usb_upload_arbiter;
  logic clk, rst, up_afull, up_valid, busy, err_timeout, err_overlen;
  logic [31:0] src_data;
  logic [3:0] src_valid, src_last, src_ready, acc;
  logic [7:0] up_data;
  logic [1:0] grant_idx;
  logic [7:0] qd[4][32];
  logic ql[4][32];
  logic [7:0] got[16];
  int hd[4], tl[4];
  int checks = 0, errors = 0, nbytes, cnt, ov;

  usb_upload_arbiter #(.NUM_SRC(4), .MAX_PKT_LEN(8), .IDLE_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(src_ready), .up_data(up_data),
    .up_valid(up_valid), .up_afull(up_afull), .grant_idx(grant_idx),
    .busy(busy), .err_timeout(err_timeout), .err_overlen(err_overlen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] b, input logic l);
    qd[s][tl[s]] = b;
    ql[s][tl[s]] = l;
    tl[s]++;
  endtask

  // present queued bytes, handshake on the falling edge view, pop after the rising edge
  task automatic cyc();
    for (int i = 0; i < 4; i++) begin
      src_valid[i] = hd[i] < tl[i];
      src_data[8*i +: 8] = src_valid[i] ? qd[i][hd[i]] : 8'h00;
      src_last[i] = src_valid[i] && ql[i][hd[i]];
    end
    @(negedge clk);
    acc = src_valid & src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) hd[i]++;
  endtask

  initial begin
    rst = 1'b1;
    up_afull = 1'b0;
    src_valid = '0;
    src_last = '0;
    src_data = '0;
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    cyc();
    cyc();
    chk("rst_up_valid", up_valid, 0);
    chk("rst_up_data", up_data, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_err_ov", err_overlen, 0);
    chk("rst_ready", src_ready, 0);
    rst = 1'b0;

    push(0, 8'h01, 0); push(0, 8'h02, 1); push(0, 8'h05, 0); push(0, 8'h06, 1);
    for (int s = 1; s < 4; s++) begin
      push(s, 8'(16 * s + 1), 0);
      push(s, 8'(16 * s + 2), 1);
    end
    for (int c = 0; c < 15; c++) begin
      int p, ph;
      p = c / 3;
      ph = c % 3;
      cyc();
      chk("rr_grant", grant_idx, p % 4);
      chk("rr_valid", up_valid, ph != 0);
      chk("rr_busy", busy, ph != 2);
      if (ph != 0) chk("rr_data", up_data, p < 4 ? 16 * (p % 4) + ph : (ph == 1 ? 5 : 6));
    end

    push(1, 8'hA1, 0); push(1, 8'hA2, 0); push(1, 8'hA3, 1);
    cyc();
    chk("one_grant", grant_idx, 1);
    chk("one_busy", busy, 1);
    chk("one_nobyte", up_valid, 0);
    chk("one_ready", src_ready, 4'b0010);
    cyc();
    chk("one_v1", up_valid, 1);
    chk("one_d1", up_data, 8'hA1);
    cyc();
    chk("one_v2", up_valid, 1);
    chk("one_d2", up_data, 8'hA2);
    cyc();
    chk("one_v3", up_valid, 1);
    chk("one_d3", up_data, 8'hA3);
    chk("one_busy_end", busy, 0);
    cyc();
    chk("one_v4", up_valid, 0);

    for (int b = 0; b < 6; b++) push(2, 8'(8'hC0 + b), b == 5);
    nbytes = 0;
    for (int c = 1; c <= 14; c++) begin
      up_afull = c >= 4 && c <= 8;
      cyc();
      if (c >= 4 && c <= 8) begin
        chk("bp_valid", up_valid, 0);
        chk("bp_ready", src_ready, 0);
      end
      if (up_valid) begin
        if (nbytes < 16) got[nbytes] = up_data;
        nbytes++;
      end
    end
    up_afull = 1'b0;
    chk("bp_count", nbytes, 6);
    for (int b = 0; b < 6; b++) chk("bp_byte", got[b], 8'hC0 + b);

    push(2, 8'h5E, 0);
    cyc();
    chk("to_grant2", grant_idx, 2);
    cyc();
    chk("to_byte", up_data, 8'h5E);
    push(3, 8'h3C, 0); push(3, 8'h3D, 1);
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      cyc();
      cnt += int'(err_timeout);
    end
    chk("to_early_busy", busy, 1);
    chk("to_early_pulse", cnt, 0);
    cyc();
    cnt += int'(err_timeout);
    chk("to_release", busy, 0);
    cyc();
    cnt += int'(err_timeout);
    chk("to_pulse", cnt, 1);
    chk("to_grant3", grant_idx, 3);
    chk("to_busy3", busy, 1);
    cyc();
    chk("to_d3a", up_data, 8'h3C);
    cyc();
    chk("to_d3b", up_data, 8'h3D);
    chk("to_no_ov", err_overlen, 0);

    for (int b = 0; b < 10; b++) push(0, 8'(8'hE0 + b), 0);
    push(1, 8'h77, 1);
    nbytes = 0;
    ov = 0;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      ov += int'(err_overlen);
      if (up_valid) begin
        if (nbytes < 16) got[nbytes] = up_data;
        nbytes++;
      end
      if (c == 9) chk("ov_release", busy, 0);
      if (c == 10) chk("ov_grant1", grant_idx, 1);
      if (c == 12) chk("ov_regrant0", grant_idx, 0);
    end
    chk("ov_pulse", ov, 1);
    chk("ov_count", nbytes, 11);
    for (int k = 0; k < 11; k++)
      chk("ov_byte", got[k], k < 8 ? 8'hE0 + k : (k == 8 ? 8'h77 : 8'hE0 + k - 1));
    cnt = 0;
    for (int c = 0; c < 18; c++) begin
      cyc();
      cnt += int'(err_timeout);
      ov += int'(err_overlen);
    end
    chk("ov_tail_timeout", cnt, 1);
    chk("ov_single", ov, 1);

    push(2, 8'hD0, 0); push(2, 8'hD1, 0); push(2, 8'hD2, 1);
    cyc();
    chk("mr_grant2", grant_idx, 2);
    cyc();
    chk("mr_d0", up_data, 8'hD0);
    rst = 1'b1;
    cyc();
    chk("mr_valid", up_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_grant", grant_idx, 0);
    chk("mr_data", up_data, 0);
    rst = 1'b0;
    push(3, 8'h3A, 1);
    push(0, 8'h0A, 1);
    cyc();
    chk("mr_restart", grant_idx, 0);
    chk("mr_busy2", busy, 1);
    cyc();
    chk("mr_v", up_valid, 1);
    chk("mr_d", up_data, 8'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
